// File: rtl/strip_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : strip_pkg
//  Purpose  : Shared strip geometry, error codes and FSM states for the
//             strip allocator / release pair.
//  Revision : 1.0 - initial release
// ============================================================================
package strip_pkg;

    localparam int NUM_STRIPS = 13;
    localparam int ARRAY_SIZE = 128;

    localparam int STRIP_HEIGHT [NUM_STRIPS] = '{16, 16, 16, 8, 8, 7, 9, 6, 10, 5, 11, 4, 12};

    // Base y of a strip is the running sum of the heights below it.
    function automatic int strip_base(input int idx);
        int s;
        s = 0;
        for (int i = 0; i < idx; i++) begin
            s += STRIP_HEIGHT[i];
        end
        return s;
    endfunction

    localparam logic [7:0] STRIP_BASE_Y [NUM_STRIPS] = '{
        8'(strip_base(0)),  8'(strip_base(1)),  8'(strip_base(2)),
        8'(strip_base(3)),  8'(strip_base(4)),  8'(strip_base(5)),
        8'(strip_base(6)),  8'(strip_base(7)),  8'(strip_base(8)),
        8'(strip_base(9)),  8'(strip_base(10)), 8'(strip_base(11)),
        8'(strip_base(12))
    };

    typedef enum logic [1:0] {
        ERR_OK          = 2'd0,
        ERR_BAD_Y       = 2'd1,
        ERR_RANGE       = 2'd2,
        ERR_DOUBLE_FREE = 2'd3
    } rel_err_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DECODE  = 3'd1,
        ST_CHECK   = 3'd2,
        ST_MARK    = 3'd3,
        ST_RETRACT = 3'd4,
        ST_RESP    = 3'd5
    } rel_state_e;

endpackage
`default_nettype wire

// File: rtl/strip_release_unit_y_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : strip_y_decoder
//  Purpose  : Registered base-y matcher, one strip examined per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module strip_y_decoder
    import strip_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] y_i,
    input  logic       step_i,
    output logic       hit_o,
    output logic [3:0] idx_o
);

    logic [7:0] r_y;
    logic [3:0] r_idx;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_y   <= '0;
            r_idx <= '0;
        end else if (start_i) begin
            r_y   <= y_i;
            r_idx <= '0;
        end else if (step_i) begin
            r_idx <= r_idx + 4'd1;
        end
    end

    assign hit_o = (r_y == STRIP_BASE_Y[r_idx]);
    assign idx_o = r_idx;

endmodule
`default_nettype wire

// File: rtl/strip_release_unit.sv
`default_nettype none
// ============================================================================
//  Module   : strip_release_unit
//  Purpose  : Frees allocated columns per strip and retracts strip fill levels.
//  Revision : 1.0 - initial release
// ============================================================================
module strip_release_unit
    import strip_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rel_valid_i,
    output logic                  rel_ready_o,
    input  logic [7:0]            rel_x_i,
    input  logic [7:0]            rel_y_i,
    input  logic [5:0]            rel_width_i,
    input  logic [NUM_STRIPS*8-1:0] fill_levels_i,
    output logic                  done_valid_o,
    output logic [1:0]            done_err_o,
    output logic [3:0]            done_strip_o,
    output logic                  retract_valid_o,
    output logic [3:0]            retract_strip_o,
    output logic [7:0]            retract_amount_o
);

    localparam logic [3:0]            c_last_strip = 4'(NUM_STRIPS - 1);
    localparam logic [ARRAY_SIZE-1:0] c_one        = ARRAY_SIZE'(1);

    rel_state_e r_state, w_next;
    rel_err_e   r_err;
    logic [7:0] r_x, r_fill, r_ptr, r_count;
    logic [5:0] r_w;
    logic [ARRAY_SIZE-1:0] r_bitmap [NUM_STRIPS];

    logic                  w_accept, w_hit, w_step;
    logic [3:0]            w_idx;
    logic [7:0]            w_fill;
    logic [8:0]            w_end;
    logic [ARRAY_SIZE-1:0] w_mask, w_bm_sel;
    logic                  w_range, w_dbl, w_at_fill, w_ret_go;
    logic [6:0]            w_ptr_m1;

    assign w_accept = (r_state == ST_IDLE) && rel_valid_i;
    assign w_step   = (r_state == ST_DECODE) && !w_hit && (w_idx != c_last_strip);

    strip_y_decoder u_y_decoder (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (w_accept),
        .y_i     (rel_y_i),
        .step_i  (w_step),
        .hit_o   (w_hit),
        .idx_o   (w_idx)
    );

    // Once decoded, the decoder index stays parked on the matched strip.
    assign w_fill    = fill_levels_i[{w_idx, 3'b000} +: 8];
    assign w_bm_sel  = r_bitmap[w_idx];
    assign w_end     = {1'b0, r_x} + {3'b000, r_w};
    assign w_mask    = ((c_one << r_w) - c_one) << r_x;
    assign w_range   = (r_w == 6'd0) || (w_end > {1'b0, w_fill});
    assign w_dbl     = |(w_bm_sel & w_mask);
    assign w_at_fill = (w_end == {1'b0, r_fill});
    assign w_ptr_m1  = 7'(r_ptr - 8'd1);
    assign w_ret_go  = (r_ptr != 8'd0) && w_bm_sel[w_ptr_m1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (rel_valid_i) w_next = ST_DECODE;
            ST_DECODE:  if (w_hit) w_next = ST_CHECK;
                        else if (w_idx == c_last_strip) w_next = ST_RESP;
            ST_CHECK:   w_next = (w_range || w_dbl) ? ST_RESP : ST_MARK;
            ST_MARK:    w_next = w_at_fill ? ST_RETRACT : ST_RESP;
            ST_RETRACT: if (!w_ret_go) w_next = ST_RESP;
            ST_RESP:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rel_ready_o      = (r_state == ST_IDLE);
        done_valid_o     = 1'b0;
        done_err_o       = 2'd0;
        done_strip_o     = 4'd0;
        retract_valid_o  = 1'b0;
        retract_strip_o  = 4'd0;
        retract_amount_o = 8'd0;
        if (r_state == ST_RESP) begin
            done_valid_o     = 1'b1;
            done_err_o       = r_err;
            done_strip_o     = (r_err == ERR_BAD_Y) ? 4'd0 : w_idx;
            retract_valid_o  = (r_count != 8'd0);
            retract_strip_o  = w_idx;
            retract_amount_o = r_count;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_x     <= '0;
            r_w     <= '0;
            r_fill  <= '0;
            r_ptr   <= '0;
            r_count <= '0;
            r_err   <= ERR_OK;
        end else begin
            case (r_state)
                ST_IDLE: if (rel_valid_i) begin
                    r_x     <= rel_x_i;
                    r_w     <= rel_width_i;
                    r_count <= '0;
                    r_err   <= ERR_OK;
                end
                ST_DECODE: if (!w_hit && (w_idx == c_last_strip)) r_err <= ERR_BAD_Y;
                ST_CHECK: begin
                    r_fill <= w_fill;
                    if (w_range)    r_err <= ERR_RANGE;
                    else if (w_dbl) r_err <= ERR_DOUBLE_FREE;
                end
                ST_MARK: r_ptr <= r_fill;
                ST_RETRACT: if (w_ret_go) begin
                    r_ptr   <= r_ptr - 8'd1;
                    r_count <= r_count + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Only the strip currently selected by the decoder is ever written.
    for (genvar gi = 0; gi < NUM_STRIPS; gi++) begin : g_strip
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_bitmap[gi] <= '0;
            end else if (w_idx == 4'(gi)) begin
                if (r_state == ST_MARK)
                    r_bitmap[gi] <= r_bitmap[gi] | w_mask;
                else if ((r_state == ST_RETRACT) && w_ret_go)
                    r_bitmap[gi][w_ptr_m1] <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
